// File: rtl/sfifo_pkt_if.sv
// Packet FIFO bus: producer write side plus first-word-fall-through read side.
// SFIFO_PKT_OVERFLOW_DROP_EN adds the o_overflow pulse.
interface sfifo_pkt_if #(
   parameter int BW     = 8,
   parameter int LGFLEN = 4,
   parameter int LGPKTS = 4
);
   logic              i_wr;
   logic [BW-1:0]     i_data;
   logic              i_last;
   logic              i_drop;
   logic              o_full;
   logic [LGFLEN:0]   o_space;
   logic [LGFLEN:0]   i_afull_thresh;
   logic              o_afull;
   logic              i_rd;
   logic [BW-1:0]     o_data;
   logic              o_last;
   logic              o_empty;
   logic [LGFLEN:0]   o_fill;
   logic [LGPKTS-1:0] o_pkts;
`ifdef SFIFO_PKT_OVERFLOW_DROP_EN
   logic              o_overflow;
`endif

   modport slave (
      input  i_wr, i_data, i_last, i_drop, i_afull_thresh, i_rd,
      output o_full, o_space, o_afull, o_data, o_last, o_empty, o_fill,
`ifdef SFIFO_PKT_OVERFLOW_DROP_EN
      output o_overflow,
`endif
      output o_pkts
   );

   modport master (
      output i_wr, i_data, i_last, i_drop, i_afull_thresh, i_rd,
      input  o_full, o_space, o_afull, o_data, o_last, o_empty, o_fill,
`ifdef SFIFO_PKT_OVERFLOW_DROP_EN
      input  o_overflow,
`endif
      input  o_pkts
   );
endinterface

// File: rtl/sfifo_pkt_mem.sv
// Packet FIFO storage: one synchronous write port, one asynchronous read port.
module sfifo_pkt_mem #(
   parameter int W      = 9,
   parameter int LGFLEN = 4
) (
   input  logic              clk,
   input  logic              we,
   input  logic [LGFLEN-1:0] waddr,
   input  logic [W-1:0]      wdata,
   input  logic [LGFLEN-1:0] raddr,
   output logic [W-1:0]      rdata
);
   logic [W-1:0] mem [1<<LGFLEN];

   always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;

   assign rdata = mem[raddr];
endmodule

// File: rtl/sfifo_pkt.sv
// Packet FIFO: speculative writes become readable only on commit of the last word.
// Define SFIFO_PKT_OVERFLOW_DROP_EN to discard over-long packets instead of stalling.
module sfifo_pkt #(
   parameter int BW     = 8,
   parameter int LGFLEN = 4,
   parameter int LGPKTS = 4
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   sfifo_pkt_if.slave  bus
);
   localparam int PW = LGFLEN + 1;
   localparam logic [PW-1:0]     FLEN    = {1'b1, {LGFLEN{1'b0}}};
   localparam logic [LGPKTS-1:0] PKT_MAX = '1;

   logic [PW-1:0]     wr_ptr, cm_ptr, rd_ptr;
   logic [PW-1:0]     wr_nxt, cm_nxt, rd_nxt;
   logic [PW-1:0]     inflight;
   logic              full_q, empty_q;
   logic [LGPKTS-1:0] pkts;
   logic              w_wr, w_rd, w_cmt, w_pop_last, roll;
   logic [BW-1:0]     head_data;
   logic              head_last;

`ifdef SFIFO_PKT_OVERFLOW_DROP_EN
   logic ovf, ovf_pulse, bad;

   // Once a packet overflows, every further word is discarded until its last word.
   assign bad  = bus.i_wr && !bus.i_drop && (full_q || ovf);
   assign w_wr = bus.i_wr && !bus.i_drop && !full_q && !ovf;
   assign roll = bad && bus.i_last;
   assign bus.o_full     = 1'b0;
   assign bus.o_overflow = ovf_pulse;

   always_ff @(posedge i_clk or negedge i_reset_n)
      if (!i_reset_n) begin
         ovf       <= 1'b0;
         ovf_pulse <= 1'b0;
      end else begin
         ovf_pulse <= roll;
         if (bus.i_drop || roll) ovf <= 1'b0;
         else if (bad)           ovf <= 1'b1;
      end
`else
   assign w_wr = bus.i_wr && !bus.i_drop && !full_q;
   assign roll = 1'b0;
   assign bus.o_full = full_q;
`endif

   assign w_cmt      = w_wr && bus.i_last;
   assign w_rd       = bus.i_rd && !empty_q;
   assign w_pop_last = w_rd && head_last;

   always_comb begin
      wr_nxt = wr_ptr;
      cm_nxt = cm_ptr;
      rd_nxt = rd_ptr;
      if (bus.i_drop || roll) wr_nxt = cm_ptr;
      else if (w_wr)          wr_nxt = wr_ptr + PW'(1);
      if (w_cmt) cm_nxt = wr_ptr + PW'(1);
      if (w_rd)  rd_nxt = rd_ptr + PW'(1);
   end

   // Flags are registered from next-state pointers so they track the pointers exactly.
   always_ff @(posedge i_clk or negedge i_reset_n)
      if (!i_reset_n) begin
         wr_ptr  <= '0;
         cm_ptr  <= '0;
         rd_ptr  <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         wr_ptr  <= wr_nxt;
         cm_ptr  <= cm_nxt;
         rd_ptr  <= rd_nxt;
         full_q  <= (wr_nxt - rd_nxt) == FLEN;
         empty_q <= cm_nxt == rd_nxt;
      end

   always_ff @(posedge i_clk or negedge i_reset_n)
      if (!i_reset_n) pkts <= '0;
      else begin
         case ({w_cmt, w_pop_last})
            2'b10:   if (pkts != PKT_MAX) pkts <= pkts + LGPKTS'(1);
            2'b01:   if (pkts != '0)      pkts <= pkts - LGPKTS'(1);
            default: ;
         endcase
      end

   sfifo_pkt_mem #(.W(BW+1), .LGFLEN(LGFLEN)) u_mem (
      .clk   (i_clk),
      .we    (w_wr),
      .waddr (wr_ptr[LGFLEN-1:0]),
      .wdata ({bus.i_last, bus.i_data}),
      .raddr (rd_ptr[LGFLEN-1:0]),
      .rdata ({head_last, head_data})
   );

   assign inflight    = wr_ptr - rd_ptr;
   assign bus.o_space = FLEN - inflight;
   assign bus.o_fill  = cm_ptr - rd_ptr;
   assign bus.o_afull = inflight >= bus.i_afull_thresh;
   assign bus.o_empty = empty_q;
   assign bus.o_pkts  = pkts;
   assign bus.o_data  = head_data;
   assign bus.o_last  = head_last;
endmodule

// File: tb/tb_sfifo_pkt.sv
// Bench for sfifo_pkt: directed table, hand sequences and random traffic vs a queue model.
// Covers the SFIFO_PKT_OVERFLOW_DROP_EN build when that macro is defined.
module tb_sfifo_pkt;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   sfifo_pkt_if #(.BW(8), .LGFLEN(4), .LGPKTS(4)) bus ();
   sfifo_pkt #(.BW(8), .LGFLEN(4), .LGPKTS(4)) dut (
      .i_clk(clk), .i_reset_n(rst_n), .bus(bus));

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   // Reference model: committed and pending word queues.
   typedef struct { logic last; logic [7:0] d; } w_t;
   w_t cq[$];
   w_t pq[$];
   int mpkts;
   bit movf, mpulse;

   task automatic model_reset();
      cq.delete(); pq.delete(); mpkts = 0; movf = 0; mpulse = 0;
   endtask

   task automatic model_step();
      int infl;
      bit mfull, acc, ok_rd;
      int inc, dec;
      infl  = cq.size() + pq.size();
      mfull = (infl == 16);
      ok_rd = bus.i_rd && cq.size() != 0;
      inc = 0; dec = 0; mpulse = 0;
`ifdef SFIFO_PKT_OVERFLOW_DROP_EN
      acc = bus.i_wr && !bus.i_drop && !movf && !mfull;
      if (bus.i_wr && !bus.i_drop && !acc) begin
         if (bus.i_last) begin pq.delete(); movf = 0; mpulse = 1; end
         else movf = 1;
      end
      if (bus.i_drop) movf = 0;
`else
      acc = bus.i_wr && !bus.i_drop && !mfull;
`endif
      if (ok_rd) begin
         w_t h;
         h = cq.pop_front();
         if (h.last) dec = 1;
      end
      if (bus.i_drop) pq.delete();
      else if (acc) begin
         w_t w;
         w.last = bus.i_last; w.d = bus.i_data;
         pq.push_back(w);
         if (bus.i_last) begin
            foreach (pq[k]) cq.push_back(pq[k]);
            pq.delete();
            inc = 1;
         end
      end
      mpkts = mpkts + inc - dec;
      if (mpkts > 15) mpkts = 15;
      if (mpkts < 0)  mpkts = 0;
   endtask

   task automatic check_model();
      int infl;
      infl = cq.size() + pq.size();
      chk("m_empty", bus.o_empty, cq.size() == 0);
      chk("m_fill",  bus.o_fill, cq.size());
      chk("m_space", bus.o_space, 16 - infl);
      chk("m_pkts",  bus.o_pkts, mpkts);
      chk("m_afull", bus.o_afull, infl >= int'(bus.i_afull_thresh));
`ifdef SFIFO_PKT_OVERFLOW_DROP_EN
      chk("m_full", bus.o_full, 0);
      chk("m_ovf",  bus.o_overflow, mpulse);
`else
      chk("m_full", bus.o_full, infl == 16);
`endif
      if (cq.size() != 0) begin
         chk("m_data", bus.o_data, cq[0].d);
         chk("m_last", bus.o_last, cq[0].last);
      end
   endtask

   task automatic drive(input bit wr, input logic [7:0] d, input bit last, input bit drop, input bit rd);
      bus.i_wr = wr; bus.i_data = d; bus.i_last = last; bus.i_drop = drop; bus.i_rd = rd;
   endtask

   task automatic idle();
      drive(0, 8'h00, 0, 0, 0);
   endtask

   task automatic tick();
      model_step();
      @(posedge clk); #1;
   endtask

   typedef struct {
      bit wr; logic [7:0] d; bit last; bit drop; bit rd;
      bit e_empty; int e_fill; int e_pkts; int e_space;
      bit cd; logic [7:0] e_data; bit e_last;
   } vec_t;
   vec_t tbl[16];

   initial begin
      tbl[0]  = '{1, 8'hA1, 0, 0, 0,  1, 0, 0, 16,  0, 8'h00, 0};
      tbl[1]  = '{1, 8'hB2, 0, 0, 0,  1, 0, 0, 15,  0, 8'h00, 0};
      tbl[2]  = '{1, 8'hC3, 1, 0, 0,  1, 0, 0, 14,  0, 8'h00, 0};
      tbl[3]  = '{0, 8'h00, 0, 0, 0,  0, 3, 1, 13,  1, 8'hA1, 0};
      tbl[4]  = '{0, 8'h00, 0, 0, 1,  0, 3, 1, 13,  1, 8'hA1, 0};
      tbl[5]  = '{0, 8'h00, 0, 0, 1,  0, 2, 1, 14,  1, 8'hB2, 0};
      tbl[6]  = '{0, 8'h00, 0, 0, 1,  0, 1, 1, 15,  1, 8'hC3, 1};
      tbl[7]  = '{0, 8'h00, 0, 0, 0,  1, 0, 0, 16,  0, 8'h00, 0};
      tbl[8]  = '{1, 8'h11, 0, 0, 0,  1, 0, 0, 16,  0, 8'h00, 0};
      tbl[9]  = '{1, 8'h22, 0, 0, 0,  1, 0, 0, 15,  0, 8'h00, 0};
      tbl[10] = '{1, 8'h33, 1, 1, 0,  1, 0, 0, 14,  0, 8'h00, 0};
      tbl[11] = '{1, 8'hD4, 1, 0, 0,  1, 0, 0, 16,  0, 8'h00, 0};
      tbl[12] = '{0, 8'h00, 0, 0, 0,  0, 1, 1, 15,  1, 8'hD4, 1};
      tbl[13] = '{0, 8'h00, 0, 0, 1,  0, 1, 1, 15,  1, 8'hD4, 1};
      tbl[14] = '{0, 8'h00, 0, 1, 0,  1, 0, 0, 16,  0, 8'h00, 0};
      tbl[15] = '{0, 8'h00, 0, 0, 0,  1, 0, 0, 16,  0, 8'h00, 0};

      rst_n = 1'b0;
      idle();
      bus.i_afull_thresh = 5'd0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      #1;
      chk("rst_full",  bus.o_full, 0);
      chk("rst_empty", bus.o_empty, 1);
      chk("rst_fill",  bus.o_fill, 0);
      chk("rst_space", bus.o_space, 16);
      chk("rst_pkts",  bus.o_pkts, 0);
      chk("rst_afull_t0", bus.o_afull, 1);
      bus.i_afull_thresh = 5'd5;
      #1 chk("rst_afull_t5", bus.o_afull, 0);
      rst_n = 1'b1;
      bus.i_afull_thresh = 5'd12;
      @(posedge clk); #1;

      // Packet commit visibility, reads, drop and drop-as-no-op
      for (int i = 0; i < 16; i++) begin
         drive(tbl[i].wr, tbl[i].d, tbl[i].last, tbl[i].drop, tbl[i].rd);
         #2;
         chk($sformatf("tbl%0d_empty", i), bus.o_empty, tbl[i].e_empty);
         chk($sformatf("tbl%0d_fill", i),  bus.o_fill,  tbl[i].e_fill);
         chk($sformatf("tbl%0d_pkts", i),  bus.o_pkts,  tbl[i].e_pkts);
         chk($sformatf("tbl%0d_space", i), bus.o_space, tbl[i].e_space);
         if (tbl[i].cd) begin
            chk($sformatf("tbl%0d_data", i), bus.o_data, tbl[i].e_data);
            chk($sformatf("tbl%0d_last", i), bus.o_last, tbl[i].e_last);
         end
         tick();
      end

`ifndef SFIFO_PKT_OVERFLOW_DROP_EN
      // Fill to exactly 16 words, then one more write must be refused
      for (int i = 0; i < 16; i++) begin
         drive(1, 8'(i), i == 15, 0, 0);
         #2;
         chk($sformatf("fill%0d_afull", i), bus.o_afull, i >= 12);
         chk($sformatf("fill%0d_full", i),  bus.o_full, 0);
         tick();
      end
      drive(1, 8'hEE, 1, 0, 0);
      #2;
      chk("f16_full",  bus.o_full, 1);
      chk("f16_afull", bus.o_afull, 1);
      chk("f16_space", bus.o_space, 0);
      tick();
      idle();
      #2;
      chk("f17_full", bus.o_full, 1);
      chk("f17_fill", bus.o_fill, 16);
      chk("f17_pkts", bus.o_pkts, 1);
      tick();
      for (int i = 0; i < 16; i++) begin
         drive(0, 8'h00, 0, 0, 1);
         #2;
         chk($sformatf("drain%0d_data", i), bus.o_data, i);
         chk($sformatf("drain%0d_last", i), bus.o_last, i == 15);
         tick();
      end
      idle();
      #2;
      chk("drain_empty", bus.o_empty, 1);
      chk("drain_space", bus.o_space, 16);
      chk("drain_pkts",  bus.o_pkts, 0);
      tick();
`endif

      // Commit one packet while reading the last word of another
      drive(1, 8'h5A, 1, 0, 0);
      tick();
      drive(1, 8'h6B, 1, 0, 1);
      #2;
      chk("cr_pre_data", bus.o_data, 8'h5A);
      chk("cr_pre_fill", bus.o_fill, 1);
      tick();
      idle();
      #2;
      chk("cr_fill", bus.o_fill, 1);
      chk("cr_pkts", bus.o_pkts, 1);
      chk("cr_data", bus.o_data, 8'h6B);
      chk("cr_last", bus.o_last, 1);
      drive(0, 8'h00, 0, 0, 1);
      tick();
      idle();
      #2;
      chk("cr_empty", bus.o_empty, 1);
      tick();

      // Asynchronous reset in the middle of a packet
      drive(1, 8'h01, 0, 0, 0); tick();
      drive(1, 8'h02, 1, 0, 0); tick();
      drive(1, 8'h03, 0, 0, 0); tick();
      drive(1, 8'h04, 0, 0, 0);
      #2;
      chk("ar_pre_fill", bus.o_fill, 2);
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("ar_empty", bus.o_empty, 1);
      chk("ar_fill",  bus.o_fill, 0);
      chk("ar_pkts",  bus.o_pkts, 0);
      chk("ar_space", bus.o_space, 16);
      chk("ar_full",  bus.o_full, 0);
      idle();
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1 chk("ar_post_space", bus.o_space, 16);
      @(posedge clk); #1;

`ifdef SFIFO_PKT_OVERFLOW_DROP_EN
      // 20-word packet into a 16-deep FIFO is discarded without stalling the writer
      for (int i = 0; i < 20; i++) begin
         drive(1, 8'(i), i == 19, 0, 0);
         #2;
         chk($sformatf("ov%0d_full", i), bus.o_full, 0);
         chk($sformatf("ov%0d_ovf", i),  bus.o_overflow, 0);
         tick();
      end
      idle();
      #2;
      chk("ov_pulse", bus.o_overflow, 1);
      chk("ov_fill",  bus.o_fill, 0);
      chk("ov_space", bus.o_space, 16);
      tick();
      #2;
      chk("ov_pulse_end", bus.o_overflow, 0);
      drive(1, 8'h77, 1, 0, 0);
      tick();
      idle();
      #2;
      chk("ov_next_data", bus.o_data, 8'h77);
      chk("ov_next_last", bus.o_last, 1);
      chk("ov_next_fill", bus.o_fill, 1);
      drive(0, 8'h00, 0, 0, 1);
      tick();
      idle();
      tick();
`endif

      // Random traffic against the queue model
      for (int c = 0; c < 3000; c++) begin
         drive($urandom_range(99) < 60, 8'($urandom), $urandom_range(99) < 25,
               $urandom_range(99) < 5, $urandom_range(99) < 50);
         bus.i_afull_thresh = 5'($urandom_range(16));
         #2;
         check_model();
         tick();
      end
      idle();
      #2;
      check_model();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
